// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the frame bank sequencer: state encoding, counter
// widths, reset bank assignments and a saturating increment helper.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_START      = 3'd2,
    ST_PROCESS    = 3'd3,
    ST_WAIT_VSYNC = 3'd4
  } seq_state_e;

  localparam int CNT_W_DEF = 16;
  localparam int TMO_W     = 24;
  localparam int DROP_W    = 8;

  // Bank roles after reset: camera fills 0, processing reads 1, display shows 0.
  localparam logic CAM_BANK_RST  = 1'b0;
  localparam logic PROC_BANK_RST = 1'b1;
  localparam logic DISP_BANK_RST = 1'b0;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/frame_bank_sequencer_if.sv
// Signal bundle for the frame bank sequencer; master drives the control
// inputs, slave is the sequencer side.
interface frame_bank_sequencer_if
  import cnn_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             iEnable;
  logic             iCamFrameDone;
  logic [1:0]       iMode;
  logic             iProcDone;
  logic             iLcdVSync;
  logic             oCamBank;
  logic             oProcBank;
  logic             oDispBank;
  logic             oWrBank;
  logic             oProcStart;
  logic [1:0]       oMode;
  logic             oBusy;
  logic             oTimeout;
  logic [7:0]       oDropCnt;
  logic [CNT_W-1:0] oFrameCnt;

  modport master (
    output iEnable, iCamFrameDone, iMode, iProcDone, iLcdVSync,
    input  oCamBank, oProcBank, oDispBank, oWrBank, oProcStart, oMode,
           oBusy, oTimeout, oDropCnt, oFrameCnt
  );

  modport slave (
    input  iEnable, iCamFrameDone, iMode, iProcDone, iLcdVSync,
    output oCamBank, oProcBank, oDispBank, oWrBank, oProcStart, oMode,
           oBusy, oTimeout, oDropCnt, oFrameCnt
  );
endinterface

// File: rtl/seq_edge_det.sv
// Rising-edge detector against a registered previous sample.
module seq_edge_det (
  input  logic iClk,
  input  logic iRst,
  input  logic iSig,
  output logic oRise
);
  logic r_prev;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_prev <= 1'b0;
    else      r_prev <= iSig;
  end

  assign oRise = iSig & ~r_prev;
endmodule

// File: rtl/frame_bank_sequencer.sv
// Ping-pong bank sequencer: camera -> processing -> display, swapping the
// display bank on LCD vsync. Optional PROCESS watchdog: FRAME_SEQ_TIMEOUT_EN.
module frame_bank_sequencer
  import cnn_seq_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd2000000,
  parameter int               CNT_W          = CNT_W_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEnable,
  input  logic             iCamFrameDone,
  input  logic [1:0]       iMode,
  input  logic             iProcDone,
  input  logic             iLcdVSync,
  output logic             oCamBank,
  output logic             oProcBank,
  output logic             oDispBank,
  output logic             oWrBank,
  output logic             oProcStart,
  output logic [1:0]       oMode,
  output logic             oBusy,
  output logic             oTimeout,
  output logic [7:0]       oDropCnt,
  output logic [CNT_W-1:0] oFrameCnt
);

  seq_state_e       r_state, w_next;
  logic             r_cam_done;
  logic             r_pending;
  logic             r_cam_bank, r_proc_bank, r_disp_bank;
  logic [1:0]       r_mode;
  logic [7:0]       r_drop;
  logic [CNT_W-1:0] r_fcnt;
  logic             w_vs_rise;
  logic             w_take;
  logic             w_swap;
  logic             w_tmo_hit;

  seq_edge_det u_vs_edge (
    .iClk  (iClk),
    .iRst  (iRst),
    .iSig  (iLcdVSync),
    .oRise (w_vs_rise)
  );

  // Camera pulse is registered once so the start pulse lands two cycles later.
  assign w_take = (r_state == ST_WAIT_FRAME) & iEnable & (r_cam_done | r_pending);
  assign w_swap = (r_state == ST_WAIT_VSYNC) & w_vs_rise;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:       if (iEnable) w_next = ST_WAIT_FRAME;
      ST_WAIT_FRAME: begin
        if (!iEnable)                     w_next = ST_IDLE;
        else if (r_cam_done || r_pending) w_next = ST_START;
      end
      ST_START:      w_next = ST_PROCESS;
      ST_PROCESS: begin
        if (iProcDone)      w_next = ST_WAIT_VSYNC;
        else if (w_tmo_hit) w_next = ST_WAIT_FRAME;
      end
      ST_WAIT_VSYNC: if (w_vs_rise) w_next = ST_WAIT_FRAME;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    oProcStart = 1'b0;
    oBusy      = 1'b0;
    unique case (r_state)
      ST_START:                  begin oProcStart = 1'b1; oBusy = 1'b1; end
      ST_PROCESS, ST_WAIT_VSYNC: oBusy = 1'b1;
      default:                   ;
    endcase
  end

  // A frame finishing while busy is held as pending; further ones are dropped.
  // A pulse seen in WAIT_FRAME while disabled is simply not taken.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_cam_done  <= 1'b0;
      r_pending   <= 1'b0;
      r_cam_bank  <= CAM_BANK_RST;
      r_proc_bank <= PROC_BANK_RST;
      r_disp_bank <= DISP_BANK_RST;
      r_mode      <= 2'b00;
      r_drop      <= '0;
      r_fcnt      <= '0;
    end else begin
      r_cam_done <= iCamFrameDone;
      if (w_take) begin
        r_proc_bank <= r_cam_bank;
        r_cam_bank  <= ~r_cam_bank;
        r_mode      <= iMode;
        r_pending   <= 1'b0;
      end else if (r_cam_done && (r_state != ST_WAIT_FRAME)) begin
        if (!r_pending) r_pending <= 1'b1;
        else            r_drop    <= sat_inc(r_drop);
      end
      if (w_swap) begin
        r_disp_bank <= ~r_disp_bank;
        r_fcnt      <= r_fcnt + CNT_W'(1);
      end
    end
  end

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;

  assign w_tmo_hit = (r_tmo_cnt == TIMEOUT_CYCLES - TMO_W'(1));

  // Counter only runs inside PROCESS and restarts on every entry.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if ((r_state == ST_PROCESS) && !iProcDone) begin
      if (w_tmo_hit) begin
        r_tmo_cnt <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign oTimeout = r_timeout;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
  assign oTimeout     = 1'b0;
`endif

  assign oCamBank  = r_cam_bank;
  assign oProcBank = r_proc_bank;
  assign oDispBank = r_disp_bank;
  assign oWrBank   = ~r_disp_bank;
  assign oMode     = r_mode;
  assign oDropCnt  = r_drop;
  assign oFrameCnt = r_fcnt;

endmodule

// File: tb/tb_frame_bank_sequencer.sv
// Directed + randomized bench for frame_bank_sequencer with a behavioural model.
module tb_frame_bank_sequencer;
  localparam int CNT_W = 16;
  localparam int TMO   = 100;

  localparam int P_IDLE  = 0;
  localparam int P_WAITF = 1;
  localparam int P_START = 2;
  localparam int P_PROC  = 3;
  localparam int P_WAITV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_bank_sequencer_if #(.CNT_W(CNT_W)) bus ();

  frame_bank_sequencer #(.TIMEOUT_CYCLES(24'd100), .CNT_W(CNT_W)) dut (
    .iClk          (clk),
    .iRst          (rst),
    .iEnable       (bus.iEnable),
    .iCamFrameDone (bus.iCamFrameDone),
    .iMode         (bus.iMode),
    .iProcDone     (bus.iProcDone),
    .iLcdVSync     (bus.iLcdVSync),
    .oCamBank      (bus.oCamBank),
    .oProcBank     (bus.oProcBank),
    .oDispBank     (bus.oDispBank),
    .oWrBank       (bus.oWrBank),
    .oProcStart    (bus.oProcStart),
    .oMode         (bus.oMode),
    .oBusy         (bus.oBusy),
    .oTimeout      (bus.oTimeout),
    .oDropCnt      (bus.oDropCnt),
    .oFrameCnt     (bus.oFrameCnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    else             n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: tracks which phase of the frame pipeline we are in.
  int   m_phase, m_drop, m_fcnt, m_tcnt;
  bit   m_cam, m_proc, m_disp, m_pend, m_tmo, m_cam_seen, m_vs_last;
  logic [1:0] m_mode;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_cam = 0; m_proc = 1; m_disp = 0; m_mode = 2'b00;
      m_pend = 0; m_drop = 0; m_fcnt = 0; m_tmo = 0; m_tcnt = 0;
      m_cam_seen = 0; m_vs_last = 0;
    end else begin
      bit cam_evt, vs_rise;
      int ph;
      cam_evt    = m_cam_seen;
      m_cam_seen = bus.iCamFrameDone;
      vs_rise    = bus.iLcdVSync && !m_vs_last;
      m_vs_last  = bus.iLcdVSync;
      ph         = m_phase;
      if (cam_evt && ph != P_WAITF) begin
        if (!m_pend) m_pend = 1;
        else if (m_drop < 255) m_drop = m_drop + 1;
      end
      if (ph != P_PROC) m_tcnt = 0;
      case (ph)
        P_IDLE:  if (bus.iEnable) m_phase = P_WAITF;
        P_WAITF: begin
          if (!bus.iEnable) m_phase = P_IDLE;
          else if (cam_evt || m_pend) begin
            m_proc = m_cam; m_cam = !m_cam; m_mode = bus.iMode; m_pend = 0;
            m_phase = P_START;
          end
        end
        P_START: m_phase = P_PROC;
        P_PROC: begin
          if (bus.iProcDone) begin
            m_phase = P_WAITV; m_tcnt = 0;
          end else begin
`ifdef FRAME_SEQ_TIMEOUT_EN
            if (m_tcnt == TMO - 1) begin
              m_tmo = 1; m_phase = P_WAITF; m_tcnt = 0;
            end else m_tcnt = m_tcnt + 1;
`endif
          end
        end
        P_WAITV: if (vs_rise) begin
          m_disp = !m_disp; m_fcnt = (m_fcnt + 1) % (1 << CNT_W);
          m_phase = P_WAITF;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cam_bank",  bus.oCamBank,   m_cam);
    chk("proc_bank", bus.oProcBank,  m_proc);
    chk("disp_bank", bus.oDispBank,  m_disp);
    chk("wr_bank",   bus.oWrBank,    !m_disp);
    chk("proc_start",bus.oProcStart, m_phase == P_START);
    chk("busy",      bus.oBusy,      m_phase == P_START || m_phase == P_PROC || m_phase == P_WAITV);
    chk("mode",      bus.oMode,      m_mode);
    chk("timeout",   bus.oTimeout,   m_tmo);
    chk("drop_cnt",  bus.oDropCnt,   m_drop);
    chk("frame_cnt", bus.oFrameCnt,  m_fcnt);
  end

  initial begin
    bus.iEnable = 0; bus.iCamFrameDone = 0; bus.iMode = 2'b00;
    bus.iProcDone = 0; bus.iLcdVSync = 0;
    rst = 1;
    step(2);
    rst = 0;
    // reset state
    chk("rst_cam", bus.oCamBank, 0);   chk("rst_proc", bus.oProcBank, 1);
    chk("rst_disp", bus.oDispBank, 0); chk("rst_wr", bus.oWrBank, 1);
    chk("rst_busy", bus.oBusy, 0);     chk("rst_fcnt", bus.oFrameCnt, 0);
    chk("rst_drop", bus.oDropCnt, 0);  chk("rst_tmo", bus.oTimeout, 0);

    // frame 1: pulse at cycle 10, start at 12, done at 50, vsync at 80
    bus.iEnable = 1; bus.iMode = 2'b10;
    step(10);
    bus.iCamFrameDone = 1; step(1); bus.iCamFrameDone = 0;
    chk("f1_start_c11", bus.oProcStart, 0);
    step(1);
    chk("f1_start_c12", bus.oProcStart, 1);
    chk("f1_cam", bus.oCamBank, 1); chk("f1_proc", bus.oProcBank, 0);
    chk("f1_mode", bus.oMode, 2'b10);
    bus.iMode = 2'b01;
    step(1);
    chk("f1_start_c13", bus.oProcStart, 0); chk("f1_busy", bus.oBusy, 1);
    chk("f1_mode_hold", bus.oMode, 2'b10);
    step(37);
    bus.iProcDone = 1; step(1); bus.iProcDone = 0;
    step(29);
    bus.iLcdVSync = 1; step(1);
    chk("f1_disp", bus.oDispBank, 1); chk("f1_wr", bus.oWrBank, 0);
    chk("f1_fcnt", bus.oFrameCnt, 1); chk("f1_idle_busy", bus.oBusy, 0);
    bus.iLcdVSync = 0;

    // frame 2: mode latched at start only; three pulses while busy
    bus.iMode = 2'b00;
    bus.iCamFrameDone = 1; step(1); bus.iCamFrameDone = 0; step(1);
    chk("f2_start", bus.oProcStart, 1); chk("f2_mode", bus.oMode, 2'b00);
    chk("f2_cam", bus.oCamBank, 0);     chk("f2_proc", bus.oProcBank, 1);
    step(1);
    bus.iMode = 2'b01;
    for (int k = 0; k < 3; k++) begin
      bus.iCamFrameDone = 1; step(1); bus.iCamFrameDone = 0; step(2);
    end
    step(2);
    chk("f2_drop", bus.oDropCnt, 2); chk("f2_mode_hold", bus.oMode, 2'b00);
    bus.iProcDone = 1; step(1); bus.iProcDone = 0; step(3);
    bus.iLcdVSync = 1; step(1);
    chk("f2_disp", bus.oDispBank, 0); chk("f2_fcnt", bus.oFrameCnt, 2);
    chk("f2_wf_start", bus.oProcStart, 0);
    step(1);
    chk("f3_auto_start", bus.oProcStart, 1); chk("f3_mode", bus.oMode, 2'b01);
    chk("f3_cam", bus.oCamBank, 1);

    // frame 3: done and vsync edge in the same cycle -> no swap
    step(1);
    bus.iLcdVSync = 0; step(2);
    bus.iProcDone = 1; bus.iLcdVSync = 1; step(1); bus.iProcDone = 0;
    chk("f3_noswap_disp", bus.oDispBank, 0); chk("f3_noswap_busy", bus.oBusy, 1);
    step(3);
    chk("f3_hold_disp", bus.oDispBank, 0);
    bus.iLcdVSync = 0; step(1); bus.iLcdVSync = 1; step(1);
    chk("f3_swap_disp", bus.oDispBank, 1); chk("f3_fcnt", bus.oFrameCnt, 3);
    bus.iLcdVSync = 0;

`ifdef FRAME_SEQ_TIMEOUT_EN
    bus.iCamFrameDone = 1; step(1); bus.iCamFrameDone = 0; step(1);
    chk("to_start", bus.oProcStart, 1);
    step(100);
    chk("to_pre_flag", bus.oTimeout, 0); chk("to_pre_busy", bus.oBusy, 1);
    step(1);
    chk("to_flag", bus.oTimeout, 1); chk("to_busy", bus.oBusy, 0);
    chk("to_disp", bus.oDispBank, 1); chk("to_fcnt", bus.oFrameCnt, 3);
`endif

    // reset during PROCESS discards the frame
    bus.iCamFrameDone = 1; step(1); bus.iCamFrameDone = 0; step(3);
    chk("rp_busy", bus.oBusy, 1);
    rst = 1; step(1); rst = 0;
    chk("rp_cam", bus.oCamBank, 0); chk("rp_proc", bus.oProcBank, 1);
    chk("rp_disp", bus.oDispBank, 0); chk("rp_fcnt", bus.oFrameCnt, 0);
    chk("rp_busy0", bus.oBusy, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bus.iEnable       = ($urandom_range(0, 40) != 0);
      bus.iCamFrameDone = ($urandom_range(0, 14) == 0);
      bus.iProcDone     = ($urandom_range(0, 12) == 0);
      bus.iMode         = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 6) == 0) bus.iLcdVSync = !bus.iLcdVSync;
      rst = ($urandom_range(0, 700) == 0);
      step(1);
    end
    rst = 0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
